// File: rtl/rv32i_mc_control.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXECUTE/MEM/WB sequencing with a memory
// wait watchdog and a sticky trap state that only reset can leave.
module rv32i_mc_control #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_code,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        branch_taken,
    output logic        imem_req,
    output logic        ir_load,
    output logic        pc_wr_en,
    output logic [1:0]  pc_src,
    output logic        reg_wr_en,
    output logic [3:0]  alu_controls,
    output logic        aluSrcMuxSel,
    output logic [2:0]  RegWdataSel,
    output logic        dmem_req,
    output logic        d_wr_en,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic        retired,
    output logic [2:0]  state
);

    localparam logic [2:0] StFetch   = 3'd0;
    localparam logic [2:0] StDecode  = 3'd1;
    localparam logic [2:0] StExecute = 3'd2;
    localparam logic [2:0] StMem     = 3'd3;
    localparam logic [2:0] StWb      = 3'd4;
    localparam logic [2:0] StTrap    = 3'd5;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    localparam bit WdogEn = (TIMEOUT != 0);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;
    logic [31:0]      ir_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_r, is_imm, is_load, is_store, is_branch, is_lui, is_auipc, is_jal, is_jalr;
    logic       legal;
    logic       wait_expired;

    // Private copy of the fetched word so decode does not depend on the external IR timing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_q <= '0;
        end else if (ir_load) begin
            ir_q <= instr_code;
        end
    end

    assign opcode    = ir_q[6:0];
    assign funct3    = ir_q[14:12];
    assign is_r      = (opcode == OpR);
    assign is_imm    = (opcode == OpImm);
    assign is_load   = (opcode == OpLoad);
    assign is_store  = (opcode == OpStore);
    assign is_branch = (opcode == OpBranch);
    assign is_lui    = (opcode == OpLui);
    assign is_auipc  = (opcode == OpAuipc);
    assign is_jal    = (opcode == OpJal);
    assign is_jalr   = (opcode == OpJalr);
    assign legal     = is_r | is_imm | is_load | is_store | is_branch | is_lui | is_auipc |
                       is_jal | is_jalr;

    // Fires on the cycle whose low ready would bring the count up to TIMEOUT.
    assign wait_expired = WdogEn && ((32'(cnt_q) + 32'd1) == 32'(TIMEOUT));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        unique case (state_q)
            StFetch: begin
                if (imem_ready) begin
                    state_d = StDecode;
                end else if (wait_expired) begin
                    state_d = StTrap;
                    cause_d = 2'd2;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDecode: begin
                if (legal) begin
                    state_d = StExecute;
                end else begin
                    state_d = StTrap;
                    cause_d = 2'd1;
                end
            end
            StExecute: begin
                if (is_load || is_store) begin
                    state_d = StMem;
                end else if (is_branch) begin
                    state_d = StFetch;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (dmem_ready) begin
                    state_d = is_store ? StFetch : StWb;
                end else if (wait_expired) begin
                    state_d = StTrap;
                    cause_d = 2'd3;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWb:    state_d = StFetch;
            StTrap:  state_d = StTrap;
            default: state_d = StFetch;
        endcase
        // Any state change clears the counter, which covers every entry into FETCH and MEM.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
            cnt_q   <= '0;
            cause_q <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        // Gated with reset so the fetch request stays low while reset is held.
        imem_req  = reset && (state_q == StFetch);
        ir_load   = reset && (state_q == StFetch) && imem_ready;
        pc_wr_en  = ((state_q == StExecute) && is_branch) ||
                    ((state_q == StMem) && is_store && dmem_ready) ||
                    (state_q == StWb);
        retired   = pc_wr_en;
        reg_wr_en = (state_q == StWb);
        dmem_req  = (state_q == StMem);
        d_wr_en   = (state_q == StMem) && is_store;
        trap      = (state_q == StTrap);
        trap_cause = cause_q;
        state     = state_q;

        pc_src = 2'd0;
        if (is_jal) begin
            pc_src = 2'd1;
        end else if (is_jalr) begin
            pc_src = 2'd2;
        end else if (is_branch) begin
            pc_src = {1'b0, branch_taken};
        end

        alu_controls = 4'b0000;
        if (is_r) begin
            alu_controls = {ir_q[30], funct3};
        end else if (is_imm) begin
            alu_controls = {(funct3 == 3'b101) && ir_q[30], funct3};
        end

        aluSrcMuxSel = is_imm | is_load | is_store | is_jalr;

        RegWdataSel = 3'd0;
        if (is_load) begin
            RegWdataSel = 3'd1;
        end else if (is_lui) begin
            RegWdataSel = 3'd2;
        end else if (is_auipc) begin
            RegWdataSel = 3'd3;
        end else if (is_jal || is_jalr) begin
            RegWdataSel = 3'd4;
        end
    end

endmodule

// File: doc/rv32i_mc_control.md
RV32I_MC_CONTROL -- requirements
Module: rv32i_mc_control

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning: max wait cycles for imem_ready/dmem_ready (0 disables the watchdog).
REQ-002 Parameter CNT_W, default $clog2(TIMEOUT+1) (min 1), meaning: wait-counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 instr_code  input  32  instruction word; valid when imem_ready=1, held externally in IR afterwards.
REQ-006 imem_ready  input  1  instruction memory done.
REQ-007 dmem_ready  input  1  data memory done.
REQ-008 branch_taken  input  1  comparator result for current B-type instruction.
REQ-009 imem_req  output  1  instruction fetch request.
REQ-010 ir_load  output  1  latch instr_code into IR.
REQ-011 pc_wr_en  output  1  PC update strobe.
REQ-012 pc_src  output  2  0=PC+4, 1=PC+imm (branch/JAL), 2=JALR target.
REQ-013 reg_wr_en  output  1  register file write.
REQ-014 alu_controls  output  4  ALU operation.
REQ-015 aluSrcMuxSel  output  1  0=rs2, 1=immediate.
REQ-016 RegWdataSel  output  3  0=ALU, 1=dRdata, 2=imm (LUI), 3=PC+imm (AUIPC), 4=PC+4.
REQ-017 dmem_req  output  1  data access request.
REQ-018 d_wr_en  output  1  data write (store).
REQ-019 trap  output  1  sticky fault flag.
REQ-020 trap_cause  output  2  0=none, 1=illegal opcode, 2=imem timeout, 3=dmem timeout.
REQ-021 retired  output  1  one-cycle pulse per completed instruction.
REQ-022 state  output  3  FSM state: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5.

Function
REQ-023 FETCH: imem_req=1; on imem_ready=1, ir_load=1 and go to DECODE; otherwise stay.
REQ-024 DECODE: one cycle; legal opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111; any other opcode goes to TRAP with cause 1.
REQ-025 EXECUTE: one cycle; load/store go to MEM; B-type asserts pc_wr_en with pc_src=branch_taken?1:0, retired=1, and goes to FETCH; all others go to WB.
REQ-026 MEM: dmem_req=1, d_wr_en=1 only for store; on dmem_ready, store asserts pc_wr_en (pc_src=0) and retired and goes to FETCH; load goes to WB.
REQ-027 WB: reg_wr_en=1, pc_wr_en=1, retired=1; pc_src=1 for JAL, 2 for JALR, else 0; go to FETCH.
REQ-028 alu_controls: R-type {funct7[5],funct3}; I-ALU {funct7[5] only when funct3=101, funct3}; all other opcodes 0000 (ADD).
REQ-029 aluSrcMuxSel=1 for I-ALU, load, store, and JALR; 0 otherwise.
REQ-030 RegWdataSel: load=1, LUI=2, AUIPC=3, JAL/JALR=4, else 0.
REQ-031 Control outputs decode from the held instruction; they are valid in every state and don't-care where no strobe uses them.
REQ-032 Wait counter clears on entry to FETCH/MEM and increments each cycle the ready input is low.
REQ-033 If TIMEOUT!=0 and the counter reaches TIMEOUT with ready still low, go to TRAP with cause 2 (FETCH) or 3 (MEM); ready arriving on that same cycle wins, with no trap.
REQ-034 TRAP: all strobes 0, trap=1, trap_cause held; exit only by reset.
REQ-035 Instruction latency with zero-wait memories: ALU/LUI/AUIPC/JAL/JALR 4 cycles, branch 3, store 4, load 5.

Reset
REQ-036 While reset=0: state=FETCH, counter=0, trap=0, trap_cause=0, and every output is 0, including imem_req.
REQ-037 Reset asserted mid-instruction aborts it immediately with no pc_wr_en/reg_wr_en/d_wr_en pulse; imem_req=1 on the first cycle after release.

Verification
REQ-038 Zero-wait stream ADD, ADDI, LW, SW, BEQ (taken) -> retired pulses at cycles 4, 8, 13, 17, 20; BEQ pc_src=1.
REQ-039 SRAI (funct3=101, funct7=0100000) -> alu_controls=1101, aluSrcMuxSel=1; SRLI -> 0101.
REQ-040 Opcode 1111111 -> TRAP, trap_cause=1, no reg_wr_en; held for 50 cycles; reset clears it.
REQ-041 TIMEOUT=4, imem_ready low for 4 cycles -> TRAP cause 2; ready on the 4th cycle -> DECODE, no trap.
REQ-042 LW with dmem_ready after 3 cycles -> dmem_req high for 4 cycles, then WB with RegWdataSel=1.
REQ-043 Reset asserted during MEM of SW -> d_wr_en falls asynchronously, state=0, no retired pulse.
